// File: rtl/var_state.sv
// Per-variable state cell at the head of a clause-array column: holds the
// assignment, its level and mark, and handles decide/imply/conflict/backtrack.
module var_state #(
    parameter int unsigned WIDTH_LVL = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           var_value_col_i,
    input  logic [WIDTH_LVL-1:0] var_lvl_col_i,
    input  logic                 decide_i,
    input  logic [1:0]           decide_val_i,
    input  logic [WIDTH_LVL-1:0] cur_lvl_i,
    input  logic                 bkt_i,
    input  logic [WIDTH_LVL-1:0] bkt_lvl_i,
    input  logic                 clr_mark_i,
    output logic [2:0]           var_value_o,
    output logic [WIDTH_LVL-1:0] var_lvl_o,
    output logic                 assigned_o,
    output logic                 implied_o,
    output logic                 conflict_o,
    output logic                 marked_o
);

    localparam logic [1:0] CODE_FREE  = 2'b00;
    localparam logic [1:0] CODE_CONFL = 2'b11;

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_DECIDED  = 2'd1,
        ST_IMPLIED  = 2'd2,
        ST_CONFLICT = 2'd3
    } state_e;

    state_e               r_state;
    logic [WIDTH_LVL-1:0] r_lvl;

    logic [1:0] w_col_code;
    logic       w_imp_evt;
    logic       w_conf_drv;
    logic       w_dec_ok;
    logic       w_bkt_hit;

    assign w_col_code = var_value_col_i[2:1];
    assign w_imp_evt  = var_value_col_i[0];
    assign w_conf_drv = !var_value_col_i[0] && (w_col_code == CODE_CONFL);
    assign w_dec_ok   = decide_val_i[1] ^ decide_val_i[0];
    assign w_bkt_hit  = (r_state != ST_FREE) && (r_lvl > bkt_lvl_i);

    // Decoded from the registered value code, so it needs no flop of its own.
    assign assigned_o = (var_value_o[2:1] != CODE_FREE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FREE;
            r_lvl       <= '0;
            var_value_o <= 3'b000;
            var_lvl_o   <= '0;
            implied_o   <= 1'b0;
            conflict_o  <= 1'b0;
            marked_o    <= 1'b0;
        end else begin
            implied_o <= 1'b0;
            if (bkt_i) begin
                // Backtrack owns the cycle; only a deeper assignment is undone.
                if (w_bkt_hit) begin
                    r_state     <= ST_FREE;
                    r_lvl       <= '0;
                    var_value_o <= 3'b000;
                    var_lvl_o   <= '0;
                    conflict_o  <= 1'b0;
                    marked_o    <= 1'b0;
                end else if (clr_mark_i) begin
                    marked_o <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_FREE: begin
                        if (w_imp_evt) begin
                            if (w_col_code == CODE_CONFL) begin
                                r_state     <= ST_CONFLICT;
                                r_lvl       <= var_lvl_col_i;
                                var_value_o <= 3'b000;
                                var_lvl_o   <= '0;
                                conflict_o  <= 1'b1;
                            end else if (w_col_code != CODE_FREE) begin
                                r_state     <= ST_IMPLIED;
                                r_lvl       <= var_lvl_col_i;
                                var_value_o <= {w_col_code, 1'b1};
                                var_lvl_o   <= var_lvl_col_i;
                                implied_o   <= 1'b1;
                            end
                        end else if (decide_i && w_dec_ok) begin
                            r_state     <= ST_DECIDED;
                            r_lvl       <= cur_lvl_i;
                            var_value_o <= {decide_val_i, 1'b0};
                            var_lvl_o   <= cur_lvl_i;
                        end
                        if (clr_mark_i) begin
                            marked_o <= 1'b0;
                        end
                    end
                    ST_DECIDED, ST_IMPLIED: begin
                        // A mark set in the same cycle as a clear takes precedence.
                        if (w_conf_drv) begin
                            marked_o <= 1'b1;
                        end else if (clr_mark_i) begin
                            marked_o <= 1'b0;
                        end
                    end
                    default: begin
                        if (clr_mark_i) begin
                            marked_o <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_var_state.sv
// Scoreboard bench for var_state: directed steps push expected outputs keyed
// by cycle; a negedge monitor pops and compares them.
module tb_var_state;

    localparam int unsigned W = 16;
    localparam int unsigned OW = 3 + W + 4;

    logic         clk;
    logic         rst_n;
    logic [2:0]   var_value_col_i;
    logic [W-1:0] var_lvl_col_i;
    logic         decide_i;
    logic [1:0]   decide_val_i;
    logic [W-1:0] cur_lvl_i;
    logic         bkt_i;
    logic [W-1:0] bkt_lvl_i;
    logic         clr_mark_i;
    logic [2:0]   var_value_o;
    logic [W-1:0] var_lvl_o;
    logic         assigned_o;
    logic         implied_o;
    logic         conflict_o;
    logic         marked_o;

    var_state #(.WIDTH_LVL(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .var_value_col_i (var_value_col_i),
        .var_lvl_col_i   (var_lvl_col_i),
        .decide_i        (decide_i),
        .decide_val_i    (decide_val_i),
        .cur_lvl_i       (cur_lvl_i),
        .bkt_i           (bkt_i),
        .bkt_lvl_i       (bkt_lvl_i),
        .clr_mark_i      (clr_mark_i),
        .var_value_o     (var_value_o),
        .var_lvl_o       (var_lvl_o),
        .assigned_o      (assigned_o),
        .implied_o       (implied_o),
        .conflict_o      (conflict_o),
        .marked_o        (marked_o)
    );

    typedef struct {
        int            due;
        string         name;
        logic [OW-1:0] exp;
    } sb_t;

    sb_t      q[$];
    int       cyc = 0;
    int       n_cmp = 0;
    int       n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OW-1:0] pack_exp(input logic [2:0] v, input logic [W-1:0] l,
                                               input logic a, input logic i,
                                               input logic c, input logic m);
        return {v, l, a, i, c, m};
    endfunction

    function automatic void check(input string name, input logic [OW-1:0] exp);
        logic [OW-1:0] act;
        act = {var_value_o, var_lvl_o, assigned_o, implied_o, conflict_o, marked_o};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got val=%b lvl=%h asg=%b imp=%b conf=%b mark=%b, want val=%b lvl=%h asg=%b imp=%b conf=%b mark=%b",
                     name, act[OW-1 -: 3], act[W+3:4], act[3], act[2], act[1], act[0],
                     exp[OW-1 -: 3], exp[W+3:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endfunction

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            sb_t e;
            e = q.pop_front();
            check(e.name, e.exp);
        end
    end

    task automatic idle_inputs();
        var_value_col_i = 3'b000;
        var_lvl_col_i   = '0;
        decide_i        = 1'b0;
        decide_val_i    = 2'b00;
        cur_lvl_i       = '0;
        bkt_i           = 1'b0;
        bkt_lvl_i       = '0;
        clr_mark_i      = 1'b0;
    endtask

    // Apply inputs for one edge and schedule the expected post-edge outputs.
    task automatic step(input string name,
                        input logic dec, input logic [1:0] dval, input logic [W-1:0] clvl,
                        input logic [2:0] col, input logic [W-1:0] collvl,
                        input logic bkt, input logic [W-1:0] blvl, input logic clr,
                        input logic [OW-1:0] exp);
        sb_t e;
        decide_i        = dec;
        decide_val_i    = dval;
        cur_lvl_i       = clvl;
        var_value_col_i = col;
        var_lvl_col_i   = collvl;
        bkt_i           = bkt;
        bkt_lvl_i       = blvl;
        clr_mark_i      = clr;
        e.due  = cyc + 1;
        e.name = name;
        e.exp  = exp;
        q.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    logic [OW-1:0] z;

    initial begin
        z = '0;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        step("reset_idle",   0, 2'b00, 16'd0, 3'b000, 16'd0,      0, 16'd0,      0, z);
        step("decide_t_l3",  1, 2'b10, 16'd3, 3'b000, 16'd0,      0, 16'd0,      0, pack_exp(3'b100, 16'd3, 1, 0, 0, 0));
        step("decided_hold", 0, 2'b00, 16'd0, 3'b000, 16'd0,      0, 16'd0,      0, pack_exp(3'b100, 16'd3, 1, 0, 0, 0));
        step("bkt_to_0",     0, 2'b00, 16'd0, 3'b000, 16'd0,      1, 16'd0,      0, z);
        step("imply_beats_decide", 1, 2'b10, 16'd7, 3'b011, 16'd5, 0, 16'd0,    0, pack_exp(3'b011, 16'd5, 1, 1, 0, 0));
        step("implied_pulse_end",  0, 2'b00, 16'd0, 3'b000, 16'd0, 0, 16'd0,    0, pack_exp(3'b011, 16'd5, 1, 0, 0, 0));
        step("decide_ignored",     1, 2'b01, 16'd9, 3'b000, 16'd0, 0, 16'd0,    0, pack_exp(3'b011, 16'd5, 1, 0, 0, 0));
        step("bkt_eq_keep",        0, 2'b00, 16'd0, 3'b000, 16'd0, 1, 16'd5,    0, pack_exp(3'b011, 16'd5, 1, 0, 0, 0));
        step("bkt_below_free",     0, 2'b00, 16'd0, 3'b000, 16'd0, 1, 16'd4,    0, z);
        step("col_conflict",       0, 2'b00, 16'd0, 3'b111, 16'd6, 0, 16'd0,    0, pack_exp(3'b000, 16'd0, 0, 0, 1, 0));
        step("conflict_hold",      0, 2'b00, 16'd0, 3'b000, 16'd0, 0, 16'd0,    0, pack_exp(3'b000, 16'd0, 0, 0, 1, 0));
        step("conflict_bkt",       0, 2'b00, 16'd0, 3'b000, 16'd0, 1, 16'd2,    0, z);
        step("decide_f_l4",        1, 2'b01, 16'd4, 3'b000, 16'd0, 0, 16'd0,    0, pack_exp(3'b010, 16'd4, 1, 0, 0, 0));
        step("mark_set",           0, 2'b00, 16'd0, 3'b110, 16'd0, 0, 16'd0,    0, pack_exp(3'b010, 16'd4, 1, 0, 0, 1));
        step("imply_ignored",      0, 2'b00, 16'd0, 3'b111, 16'd1, 0, 16'd0,    0, pack_exp(3'b010, 16'd4, 1, 0, 0, 1));
        step("mark_clear",         0, 2'b00, 16'd0, 3'b000, 16'd0, 0, 16'd0,    1, pack_exp(3'b010, 16'd4, 1, 0, 0, 0));
        step("mark_set_wins",      0, 2'b00, 16'd0, 3'b110, 16'd0, 0, 16'd0,    1, pack_exp(3'b010, 16'd4, 1, 0, 0, 1));
        step("bkt_clears_mark",    0, 2'b00, 16'd0, 3'b000, 16'd0, 1, 16'd3,    0, z);
        step("bad_decide_val",     1, 2'b11, 16'd2, 3'b000, 16'd0, 0, 16'd0,    0, z);
        step("imply_t_l2",         0, 2'b00, 16'd0, 3'b101, 16'd2, 0, 16'd0,    0, pack_exp(3'b101, 16'd2, 1, 1, 0, 0));
        step("bkt_l2_keep",        0, 2'b00, 16'd0, 3'b000, 16'd0, 1, 16'd2,    0, pack_exp(3'b101, 16'd2, 1, 0, 0, 0));
        step("bkt_l1_free",        0, 2'b00, 16'd0, 3'b000, 16'd0, 1, 16'd1,    0, z);
        step("imply_max_lvl",      0, 2'b00, 16'd0, 3'b011, 16'hffff, 0, 16'd0, 0, pack_exp(3'b011, 16'hffff, 1, 1, 0, 0));
        step("bkt_below_max",      0, 2'b00, 16'd0, 3'b000, 16'd0, 1, 16'hfffe, 0, z);
        step("decide_t_l8",        1, 2'b10, 16'd8, 3'b000, 16'd0, 0, 16'd0,    0, pack_exp(3'b100, 16'd8, 1, 0, 0, 0));

        // Asynchronous reset between edges must clear outputs immediately.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", z);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_reset_idle",    0, 2'b00, 16'd0, 3'b000, 16'd0, 0, 16'd0,    0, z);

        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            sb_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation never compared, want %h", e.name, e.exp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d want end before 2000", cyc);
        $fatal(1, "timeout");
    end

endmodule
